// File: rtl/relogio_pkg.sv
// relogio_pkg: shared time types, limits and conversion helpers for the timekeeper
package relogio_pkg;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } hms_t;

    localparam logic [4:0] MAX_H = 5'd23;
    localparam logic [5:0] MAX_M = 6'd59;
    localparam logic [5:0] MAX_S = 6'd59;

    function automatic logic hms_valid(hms_t t);
        return (t.h <= MAX_H) && (t.m <= MAX_M) && (t.s <= MAX_S);
    endfunction

    // Returns {pm, h12}; hour 0 shows as 12, afternoon hours fold down by 12.
    function automatic logic [5:0] to_12h(logic [4:0] h);
        return {h >= 5'd12, (h == 5'd0) ? 5'd12 : (h > 5'd12) ? h - 5'd12 : h};
    endfunction

endpackage

// File: rtl/relogio_configuravel_divisor_tick.sv
// divisor_tick: programmable prescaler producing one tick per TICKS_PER_SEC enabled cycles
module divisor_tick #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESC_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count enabled cycles, wrap on the last one, hold while disabled; clr restarts the second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + PRESC_W'(1);
    end

endmodule

// File: rtl/relogio_configuravel.sv
// relogio_configuravel: hh:mm:ss timekeeper with 12/24 h display, checked time load and sticky alarm
module relogio_configuravel
    import relogio_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESC_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [4:0] set_h,
    input  logic [5:0] set_m,
    input  logic [5:0] set_s,
    input  logic       alarm_wr,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [4:0] horas,
    output logic       pm,
    output logic [5:0] minutos,
    output logic [5:0] segundos,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       alarm_flag,
    output logic       load_err
);

    hms_t       set_v, cur, inc, nxt, alm, alm_nxt;
    logic       tick, set_ok, load_ok, adv, end_of_day;
    logic [4:0] h12;

    assign set_v      = {set_h, set_m, set_s};
    assign set_ok     = hms_valid(set_v);
    assign load_ok    = load && set_ok;
    assign adv        = tick && !load_ok;
    assign end_of_day = (cur.h == MAX_H) && (cur.m == MAX_M) && (cur.s == MAX_S);

    divisor_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .PRESC_W      (PRESC_W)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load_ok),
        .tick(tick)
    );

    // Next time and alarm values: a valid load overrides the one-second increment.
    always_comb begin
        inc.s   = (cur.s == MAX_S) ? 6'd0 : cur.s + 6'd1;
        inc.m   = (cur.s != MAX_S) ? cur.m : (cur.m == MAX_M) ? 6'd0 : cur.m + 6'd1;
        inc.h   = (cur.s != MAX_S || cur.m != MAX_M) ? cur.h : (cur.h == MAX_H) ? 5'd0 : cur.h + 5'd1;
        nxt     = load_ok ? set_v : adv ? inc : cur;
        alm_nxt = (alarm_wr && set_ok) ? set_v : alm;
    end

    // Time/alarm registers and pulses; the alarm only matches when the time actually changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= '0;
            alm        <= '0;
            sec_tick   <= 1'b0;
            day_tick   <= 1'b0;
            load_err   <= 1'b0;
            alarm_flag <= 1'b0;
        end else begin
            cur        <= nxt;
            alm        <= alm_nxt;
            sec_tick   <= adv;
            day_tick   <= adv && end_of_day;
            load_err   <= (load || alarm_wr) && !set_ok;
            alarm_flag <= (alarm_en && (adv || load_ok) && nxt == alm_nxt) ? 1'b1 :
                          alarm_ack ? 1'b0 : alarm_flag;
        end
    end

    assign {pm, h12} = to_12h(cur.h);
    assign horas     = mode_12h ? h12 : cur.h;
    assign minutos   = cur.m;
    assign segundos  = cur.s;

endmodule

// File: tb/tb_relogio_configuravel.sv
// tb_relogio_configuravel: directed, table-driven and randomized checks against a seconds-of-day model
module tb_relogio_configuravel;

    localparam int T = 4;

    logic       clk = 0, rst = 1, en = 0, mode_12h = 0, load = 0;
    logic       alarm_wr = 0, alarm_en = 0, alarm_ack = 0;
    logic [4:0] set_h = 0;
    logic [5:0] set_m = 0, set_s = 0;
    logic [4:0] horas;
    logic       pm, sec_tick, day_tick, alarm_flag, load_err;
    logic [5:0] minutos, segundos;

    int total = 0, bad = 0;
    int tod, pc, atod;
    bit flag, e_sec, e_day, e_err;

    typedef struct {
        bit mode;
        int h, m, s;
        int exp_h;
        bit exp_pm;
        bit exp_err;
        int exp_m;
    } vec_t;
    vec_t tbl[8];

    relogio_configuravel #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .load(load),
        .set_h(set_h), .set_m(set_m), .set_s(set_s), .alarm_wr(alarm_wr),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .horas(horas), .pm(pm),
        .minutos(minutos), .segundos(segundos), .sec_tick(sec_tick),
        .day_tick(day_tick), .alarm_flag(alarm_flag), .load_err(load_err)
    );

    always #5 clk = ~clk;

    wire [21:0] actv = {horas, pm, minutos, segundos, sec_tick, day_tick, alarm_flag, load_err};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] expv();
        int hh, mm, ss, hr;
        hh = tod / 3600;
        mm = (tod / 60) % 60;
        ss = tod % 60;
        hr = mode_12h ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
        return {5'(hr), hh >= 12, 6'(mm), 6'(ss), e_sec, e_day, flag, e_err};
    endfunction

    task automatic model_reset();
        tod = 0; pc = 0; atod = 0; flag = 0; e_sec = 0; e_day = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit valid, lok, adv;
        int ntod, stod;
        valid = (set_h <= 23) && (set_m <= 59) && (set_s <= 59);
        stod  = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s);
        lok   = load && valid;
        adv   = en && (pc == T - 1) && !lok;
        e_sec = adv;
        e_day = adv && (tod == 86399);
        e_err = (load || alarm_wr) && !valid;
        ntod  = lok ? stod : adv ? (tod + 1) % 86400 : tod;
        pc    = lok ? 0 : en ? (pc + 1) % T : pc;
        if (alarm_wr && valid) atod = stod;
        if ((adv || lok) && alarm_en && ntod == atod) flag = 1;
        else if (alarm_ack) flag = 0;
        tod = ntod;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        chk("model", actv, expv());
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_load(int h, int m, int s);
        set_h = 5'(h); set_m = 6'(m); set_s = 6'(s);
        load = 1;
        step();
        load = 0;
    endtask

    initial begin
        int cnt, t;
        model_reset();
        #12;
        chk("rst_horas24", horas, 0);
        chk("rst_pm", pm, 0);
        chk("rst_pulses", {sec_tick, day_tick, alarm_flag, load_err}, 0);
        mode_12h = 1;
        #1;
        chk("rst_horas12", horas, 12);
        mode_12h = 0;
        step();
        rst = 0;

        en = 1;
        cnt = 0;
        repeat (16) begin
            step();
            if (sec_tick) cnt++;
        end
        chk("ticks16", cnt, 4);
        chk("seg_after16", segundos, 4);
        chk("min_after16", minutos, 0);

        do_load(23, 59, 58);
        run(4);
        chk("seg_59", segundos, 59);
        chk("pm_before_midnight", pm, 1);
        run(4);
        chk("midnight_h", horas, 0);
        chk("midnight_s", segundos, 0);
        chk("day_tick_on", day_tick, 1);
        chk("pm_after_midnight", pm, 0);
        step();
        chk("day_tick_off", day_tick, 0);

        tbl[0] = '{1, 0, 0, 0, 12, 0, 0, 0};
        tbl[1] = '{1, 12, 30, 0, 12, 1, 0, 30};
        tbl[2] = '{1, 13, 5, 0, 1, 1, 0, 5};
        tbl[3] = '{1, 13, 60, 0, 1, 1, 1, 5};
        tbl[4] = '{0, 23, 15, 9, 23, 1, 0, 15};
        tbl[5] = '{1, 11, 59, 59, 11, 0, 0, 59};
        tbl[6] = '{0, 24, 0, 0, 11, 0, 1, 59};
        tbl[7] = '{1, 12, 0, 60, 11, 0, 1, 59};
        en = 0;
        for (int i = 0; i < 8; i++) begin
            mode_12h = tbl[i].mode;
            do_load(tbl[i].h, tbl[i].m, tbl[i].s);
            chk("tbl_horas", horas, tbl[i].exp_h);
            chk("tbl_pm", pm, tbl[i].exp_pm);
            chk("tbl_min", minutos, tbl[i].exp_m);
            chk("tbl_err", load_err, tbl[i].exp_err);
            step();
            chk("tbl_err_clear", load_err, 0);
        end

        mode_12h = 0;
        en = 1;
        do_load(0, 0, 0);
        run(3);
        do_load(5, 6, 7);
        chk("wrap_load_tick", sec_tick, 0);
        chk("wrap_load_val", {horas, minutos, segundos}, {5'd5, 6'd6, 6'd7});
        step();
        chk("wrap_load_hold", {sec_tick, segundos}, {1'b0, 6'd7});

        en = 0;
        set_h = 0; set_m = 0; set_s = 5;
        alarm_wr = 1;
        step();
        alarm_wr = 0;
        alarm_en = 1;
        en = 1;
        do_load(0, 0, 3);
        run(8);
        chk("alarm_at5_seg", segundos, 5);
        chk("alarm_set", alarm_flag, 1);
        run(4);
        chk("alarm_at6_seg", segundos, 6);
        chk("alarm_sticky", alarm_flag, 1);
        alarm_ack = 1;
        step();
        alarm_ack = 0;
        chk("alarm_acked", alarm_flag, 0);
        do_load(0, 0, 3);
        run(7);
        chk("alarm_not_yet", alarm_flag, 0);
        alarm_ack = 1;
        step();
        chk("alarm_set_beats_ack", alarm_flag, 1);
        step();
        alarm_ack = 0;
        chk("alarm_ack_late", alarm_flag, 0);

        do_load(10, 20, 30);
        run(2);
        rst = 1;
        #1;
        chk("async_rst_time", {horas, minutos, segundos}, 0);
        chk("async_rst_flags", {pm, sec_tick, day_tick, alarm_flag, load_err}, 0);
        model_reset();
        step();
        rst = 0;
        run(4);
        chk("restart_count", {horas, minutos, segundos}, {5'd0, 6'd0, 6'd1});

        repeat (3000) begin
            en        = $urandom_range(0, 3) != 0;
            mode_12h  = $urandom_range(0, 1) == 1;
            load      = $urandom_range(0, 30) == 0;
            alarm_wr  = $urandom_range(0, 40) == 0;
            alarm_ack = $urandom_range(0, 10) == 0;
            alarm_en  = $urandom_range(0, 4) != 0;
            if ($urandom_range(0, 7) == 0) begin
                set_h = 5'($urandom_range(0, 31));
                set_m = 6'($urandom_range(0, 63));
                set_s = 6'($urandom_range(0, 63));
            end else begin
                t = load ? ($urandom_range(0, 1) == 1 ? 86390 + $urandom_range(0, 9) : $urandom_range(0, 86399))
                         : (tod + $urandom_range(1, 8)) % 86400;
                set_h = 5'(t / 3600);
                set_m = 6'((t / 60) % 60);
                set_s = 6'(t % 60);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
